// File: rtl/display_scan_driver.sv
// display_scan_driver
// Multiplexed 4-digit 7-segment scan driver. Each digit slot lasts SCAN_DIV
// cycles: BLANK_CYCLES with all anodes off (ghosting guard), then the rest
// with one anode driven. Digit d shows numeral (active + d) mod 8, where
// "active" is a frame index from the display sequencer. New frames are held
// pending and only take effect at the digit-0 BLANK entry, so a scan never
// shows a mix of two frames. Incoming frame indices are checked for the
// +1 mod 8 sequence; a break sets a sticky error flag.
//
// Parameters:
//   SCAN_DIV      cycles per digit slot (blank + drive), 8..2^20
//   BLANK_CYCLES  anode-off cycles at slot start, < SCAN_DIV-1
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   display_en   1 = scanning, 0 = dark (forces IDLE, clears frame_err)
//   frame_idx    frame index, qualified by frame_valid
//   frame_valid  one-cycle strobe
//   brightness   (DISPLAY_DIMMING_EN only) drive duty in quarters, 0..3
//   seg          segments {g,f,e,d,c,b,a}, active high
//   dp           decimal point, active high, lit on digit 0 only
//   an           digit anodes, active low
//   frame_ack    one-cycle pulse when a pending frame becomes active
//   frame_err    sticky sequence-error flag
// Optional feature macro: DISPLAY_DIMMING_EN (adds brightness input).
module display_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       display_en,
  input  logic [2:0] frame_idx,
  input  logic       frame_valid,
`ifdef DISPLAY_DIMMING_EN
  input  logic [1:0] brightness,
`endif
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_ack,
  output logic       frame_err
);

  localparam int DRIVE_CYCLES = SCAN_DIV - BLANK_CYCLES;
  localparam int CW = $clog2(SCAN_DIV + 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(DRIVE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      digit_reg, digit_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  logic [2:0]      active_reg;
  logic [2:0]      pend_val_reg;
  logic            pend_reg;
  logic [2:0]      last_reg;
  logic            have_last_reg;
  logic            err_reg;
  logic            ack_reg;

  logic [6:0]      seg_reg, seg_next;
  logic            dp_reg, dp_next;
  logic [3:0]      an_reg, an_next;

  logic            apply;
  logic            drive_on;
  logic [2:0]      numeral_sel;

  function automatic logic [6:0] seg_encode(input logic [2:0] n);
    case (n)
      3'd0:    seg_encode = 7'h3F;
      3'd1:    seg_encode = 7'h06;
      3'd2:    seg_encode = 7'h5B;
      3'd3:    seg_encode = 7'h4F;
      3'd4:    seg_encode = 7'h66;
      3'd5:    seg_encode = 7'h6D;
      3'd6:    seg_encode = 7'h7D;
      default: seg_encode = 7'h07;
    endcase
  endfunction

  // Scan sequencing: the slot counter restarts on every state change.
  always_comb begin
    state_next = state_reg;
    digit_next = digit_reg;
    cnt_next   = cnt_reg;
    if (!display_en) begin
      state_next = IDLE;
      digit_next = 2'd0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = BLANK;
          digit_next = 2'd0;
          cnt_next   = '0;
        end
        BLANK: begin
          if (cnt_reg == BLANK_LAST) begin
            state_next = DRIVE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_reg == DRIVE_LAST) begin
            state_next = BLANK;
            digit_next = digit_reg + 2'd1;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          digit_next = 2'd0;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Frame swap point: the edge that enters BLANK for digit 0, including the
  // first slot after IDLE.
  assign apply = (state_next == BLANK) && (digit_next == 2'd0) && (state_reg != BLANK);

`ifdef DISPLAY_DIMMING_EN
  logic [CW+2:0] on_cycles;
  assign on_cycles = (((CW+3)'(brightness) + (CW+3)'(1)) * (CW+3)'(DRIVE_CYCLES)) >> 2;
  assign drive_on  = (state_next == DRIVE) && ({3'b000, cnt_next} < on_cycles);
`else
  assign drive_on  = (state_next == DRIVE);
`endif

  // active_reg is already updated by the time DRIVE is reached (swap
  // happens at BLANK entry), so the current value is the one to show.
  assign numeral_sel = active_reg + {1'b0, digit_next};
  assign seg_next    = drive_on ? seg_encode(numeral_sel) : 7'h00;
  assign dp_next     = drive_on && (digit_next == 2'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_an
      assign an_next[gi] = ~(drive_on && (digit_next == 2'(gi)));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      digit_reg     <= 2'd0;
      cnt_reg       <= '0;
      active_reg    <= 3'd0;
      pend_val_reg  <= 3'd0;
      pend_reg      <= 1'b0;
      last_reg      <= 3'd0;
      have_last_reg <= 1'b0;
      err_reg       <= 1'b0;
      ack_reg       <= 1'b0;
      seg_reg       <= 7'h00;
      dp_reg        <= 1'b0;
      an_reg        <= 4'b1111;
    end else begin
      state_reg <= state_next;
      digit_reg <= digit_next;
      cnt_reg   <= cnt_next;
      seg_reg   <= seg_next;
      dp_reg    <= dp_next;
      an_reg    <= an_next;

      ack_reg <= apply && pend_reg;
      if (apply && pend_reg)
        active_reg <= pend_val_reg;

      // A strobe on the apply edge becomes the next pending frame while the
      // older one is applied above.
      if (frame_valid) begin
        pend_val_reg <= frame_idx;
        pend_reg     <= 1'b1;
      end else if (apply) begin
        pend_reg <= 1'b0;
      end

      if (!display_en) begin
        err_reg       <= 1'b0;
        have_last_reg <= 1'b0;
      end else if (frame_valid) begin
        if (have_last_reg && (frame_idx != last_reg + 3'd1))
          err_reg <= 1'b1;
        last_reg      <= frame_idx;
        have_last_reg <= 1'b1;
      end
    end
  end

  assign seg       = seg_reg;
  assign dp        = dp_reg;
  assign an        = an_reg;
  assign frame_ack = ack_reg;
  assign frame_err = err_reg;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed testbench for display_scan_driver with SCAN_DIV=8, BLANK_CYCLES=2
// (2 blank + 6 drive cycles per digit). Inputs change and outputs are
// sampled on the falling edge.
module tb_display_scan_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       display_en = 1'b0;
  logic [2:0] frame_idx = 3'd0;
  logic       frame_valid = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_ack;
  logic       frame_err;
`ifdef DISPLAY_DIMMING_EN
  logic [1:0] brightness = 2'd3;
`endif

  int checks = 0;
  int errors = 0;
  int ack_cnt;

  always #5 clk = ~clk;

  display_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk),
    .rst(rst),
    .display_en(display_en),
    .frame_idx(frame_idx),
    .frame_valid(frame_valid),
`ifdef DISPLAY_DIMMING_EN
    .brightness(brightness),
`endif
    .seg(seg),
    .dp(dp),
    .an(an),
    .frame_ack(frame_ack),
    .frame_err(frame_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [2:0] idx);
    frame_idx   = idx;
    frame_valid = 1'b1;
    step(1);
    frame_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b0;
    step(2);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_ack", 32'(frame_ack), 32'h0);
    check("rst_err", 32'(frame_err), 32'h0);
    rst = 1'b1;
    step(1);
    check("idle_an", 32'(an), 32'hF);

    // Basic scan timing
    display_en = 1'b1;
    step(1);                                   // P1 BLANK d0
    check("blank0_a", 32'(an), 32'hF);
    step(1);                                   // P2
    check("blank0_b", 32'(an), 32'hF);
    step(1);                                   // P3 DRIVE d0
    check("drv0_an", 32'(an), 32'hE);
    check("drv0_seg", 32'(seg), 32'h3F);
    check("drv0_dp", 32'(dp), 32'h1);
    step(5);                                   // P8 last DRIVE d0 cycle
    check("drv0_last_an", 32'(an), 32'hE);
    step(1);                                   // P9 BLANK d1
    check("blank1_an", 32'(an), 32'hF);
    check("blank1_seg", 32'(seg), 32'h0);
    check("blank1_dp", 32'(dp), 32'h0);
    step(1);
    check("blank1_b", 32'(an), 32'hF);
    step(1);                                   // P11 DRIVE d1
    check("drv1_an", 32'(an), 32'hD);
    check("drv1_seg", 32'(seg), 32'h06);
    check("drv1_dp", 32'(dp), 32'h0);

    // Frame 3 strobed mid-digit-1: no tearing until digit-0 BLANK entry
    strobe(3'd3);                              // P12
    check("mid_seg_d1", 32'(seg), 32'h06);
    check("mid_ack", 32'(frame_ack), 32'h0);
    step(7);                                   // P19 DRIVE d2
    check("drv2_an", 32'(an), 32'hB);
    check("drv2_seg_old", 32'(seg), 32'h5B);
    step(8);                                   // P27 DRIVE d3
    check("drv3_an", 32'(an), 32'h7);
    check("drv3_seg_old", 32'(seg), 32'h4F);
    step(5);                                   // P32
    check("pre_apply_ack", 32'(frame_ack), 32'h0);
    step(1);                                   // P33 BLANK d0 entry
    check("apply_ack", 32'(frame_ack), 32'h1);
    check("apply_an", 32'(an), 32'hF);
    step(1);
    check("ack_pulse_end", 32'(frame_ack), 32'h0);
    step(1);                                   // P35 DRIVE d0
    check("new_d0_seg", 32'(seg), 32'h4F);
    check("new_d0_dp", 32'(dp), 32'h1);
    step(8);                                   // P43 DRIVE d1
    check("new_d1_seg", 32'(seg), 32'h66);
    check("seq_ok_err", 32'(frame_err), 32'h0);

    // Sequence break 3 -> 5 sets sticky error
    strobe(3'd5);
    check("err_set", 32'(frame_err), 32'h1);
    step(10);
    check("err_sticky", 32'(frame_err), 32'h1);
    display_en = 1'b0;
    step(1);
    check("dis_err_clr", 32'(frame_err), 32'h0);
    check("dis_an", 32'(an), 32'hF);
    check("dis_seg", 32'(seg), 32'h0);
    display_en = 1'b1;
    step(1);                                   // Q1 BLANK d0 entry, pending 5
    check("reen_ack", 32'(frame_ack), 32'h1);
    check("reen_an", 32'(an), 32'hF);
    step(2);                                   // Q3 DRIVE d0
    check("reen_d0_seg", 32'(seg), 32'h6D);
    check("reen_d0_an", 32'(an), 32'hE);

    // 6 then 7 before an apply: only 7 applies, one ack, no error
    strobe(3'd6);                              // Q4
    strobe(3'd7);                              // Q5
    check("67_err", 32'(frame_err), 32'h0);
    ack_cnt = 0;
    for (int i = 0; i < 30; i++) begin         // Q6..Q35
      step(1);
      if (frame_ack) ack_cnt++;
    end
    check("67_ack_count", 32'(ack_cnt), 32'd1);
    check("67_d0_seg", 32'(seg), 32'h07);
    check("67_d0_an", 32'(an), 32'hE);
    step(8);                                   // Q43 DRIVE d1
    check("67_d1_seg", 32'(seg), 32'h3F);
    check("67_d1_an", 32'(an), 32'hD);
    strobe(3'd0);                              // Q44, 7 -> 0 wraps
    check("wrap_err", 32'(frame_err), 32'h0);

    // Reset during DRIVE of digit 2 with frame 0 pending
    step(7);                                   // Q51 DRIVE d2
    check("pre_rst_an", 32'(an), 32'hB);
    check("pre_rst_seg", 32'(seg), 32'h06);
    #1 rst = 1'b0;
    #1;
    check("async_an", 32'(an), 32'hF);
    check("async_seg", 32'(seg), 32'h0);
    check("async_dp", 32'(dp), 32'h0);
    check("async_ack", 32'(frame_ack), 32'h0);
    check("async_err", 32'(frame_err), 32'h0);
    step(3);
    rst = 1'b1;
    step(1);                                   // BLANK d0 entry, nothing pending
    check("post_rst_ack", 32'(frame_ack), 32'h0);
    check("post_rst_an", 32'(an), 32'hF);
    step(2);
    check("post_rst_seg", 32'(seg), 32'h3F);
    check("post_rst_dp", 32'(dp), 32'h1);
    ack_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (frame_ack) ack_cnt++;
    end
    check("post_rst_no_ack", 32'(ack_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
